// File: rtl/mult_booth_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier.
// MULT_UNSIGNED_EN widens the datapath by one bit so MULTU can reuse the signed Booth core.
package mult_pkg;

  localparam int OP_W  = 32;
`ifdef MULT_UNSIGNED_EN
  localparam int N     = 33;
`else
  localparam int N     = 32;
`endif
  localparam int PW    = 2 * N + 2;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_code_e;

  function automatic booth_code_e booth_recode(input logic [1:0] pair);
    case (pair)
      2'b01:   booth_recode = BOOTH_ADD;
      2'b10:   booth_recode = BOOTH_SUB;
      default: booth_recode = BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mult_booth_if.sv
// Control-unit side bus of the multiplier: start request, operands, product and status.
interface mult_booth_if
  import mult_pkg::*;
();

  logic                   mult_start;
  logic                   mult_unsigned;
  logic signed [OP_W-1:0] A;
  logic signed [OP_W-1:0] B;
  logic        [OP_W-1:0] hi;
  logic        [OP_W-1:0] lo;
  logic                   busy;
  logic                   done;

  modport master (output mult_start, mult_unsigned, A, B,
                  input  hi, lo, busy, done);

  modport slave  (input  mult_start, mult_unsigned, A, B,
                  output hi, lo, busy, done);

endinterface

// File: rtl/mult_booth_step.sv
// One radix-2 Booth step: recode P[1:0], add/subtract M into the upper N+1 bits, then shift right.
module booth_step
  import mult_pkg::*;
(
  input  logic        [PW-1:0] p,
  input  logic signed [N-1:0]  m,
  output logic        [PW-1:0] p_next
);

  logic signed [N:0] acc;
  logic signed [N:0] m_ext;
  logic signed [N:0] sum;

  always_comb begin
    acc   = signed'(p[PW-1:N+1]);
    m_ext = {m[N-1], m};
    sum   = acc;
    case (booth_recode(p[1:0]))
      BOOTH_ADD: sum = acc + m_ext;
      BOOTH_SUB: sum = acc - m_ext;
      default:   sum = acc;
    endcase
    // Arithmetic shift: the new top bit replicates the sign of the updated accumulator.
    p_next = {sum[N], sum, p[N:1]};
  end

endmodule

// File: rtl/mult_booth.sv
// Sequential signed 32x32 multiplier, one Booth step per clock; full product on hi/lo.
// Optional MULTU support is enabled by defining MULT_UNSIGNED_EN.
module mult_booth
  import mult_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  mult_booth_if.slave  bus
);

  state_e                state, state_nx;
  logic        [CNT_W-1:0] cnt;
  logic signed [N-1:0]   m_r;
  logic        [PW-1:0]  p_r;
  logic        [PW-1:0]  p_step;
  logic        [OP_W-1:0] hi_r, lo_r;
  logic        [N-1:0]   a_ext, b_ext;
  logic                  last_step;

`ifdef MULT_UNSIGNED_EN
  assign a_ext = bus.mult_unsigned ? {1'b0, bus.A} : {bus.A[OP_W-1], bus.A};
  assign b_ext = bus.mult_unsigned ? {1'b0, bus.B} : {bus.B[OP_W-1], bus.B};
`else
  logic unused_uns;
  assign unused_uns = bus.mult_unsigned;
  assign a_ext = bus.A;
  assign b_ext = bus.B;
`endif

  assign last_step = (cnt == CNT_W'(N - 1));

  booth_step u_step (
    .p      (p_r),
    .m      (m_r),
    .p_next (p_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.mult_start) state_nx = RUN;
      RUN:     if (last_step)      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_r  <= '0;
      p_r  <= '0;
      cnt  <= '0;
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mult_start) begin
            m_r <= signed'(a_ext);
            p_r <= {{(N+1){1'b0}}, b_ext, 1'b0};
            cnt <= '0;
          end
        end
        RUN: begin
          p_r <= p_step;
          cnt <= cnt + 1'b1;
          // P[0] is the Booth guard bit; the 2N-bit product sits just above it.
          if (last_step) {hi_r, lo_r} <= p_step[2*OP_W:1];
        end
        default: ;
      endcase
    end
  end

  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);

endmodule

// File: tb/tb_mult_booth.sv
// Directed self-checking bench for mult_booth: latency, corner products, restart, ignore and reset.
module tb_mult_booth;
  import mult_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   cyc2;
  int   done_cnt;

  mult_booth_if bus ();

  mult_booth dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.A          = a;
    bus.B          = b;
    bus.mult_start = 1'b1;
    @(negedge clk);
    bus.mult_start = 1'b0;
  endtask

  // Advances at least one cycle, then until done is seen or the budget runs out.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 200);
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    reset             = 1'b1;
    bus.mult_start    = 1'b0;
    bus.mult_unsigned = 1'b0;
    bus.A             = '0;
    bus.B             = '0;
    repeat (2) @(negedge clk);
    chk("reset_hilo", {bus.hi, bus.lo}, 64'h0);
    chk("reset_busy", {63'h0, bus.busy}, 64'h0);
    chk("reset_done", {63'h0, bus.done}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // 7 * -3
    do_start(32'd7, 32'hFFFF_FFFD);
    chk("busy_after_start", {63'h0, bus.busy}, 64'h1);
    wait_done(cyc);
    chk("lat_7x-3", 64'(cyc), 64'(N));
    chk("res_7x-3", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("busy_in_done", {63'h0, bus.busy}, 64'h0);
    @(negedge clk);
    chk("done_one_cycle", {63'h0, bus.done}, 64'h0);

    // Most-negative squared; previous product must hold during RUN
    do_start(32'h8000_0000, 32'h8000_0000);
    chk("hold_hilo_in_run", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done(cyc);
    chk("res_min_sq", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);

    do_start(32'h8000_0000, 32'd1);
    wait_done(cyc);
    chk("res_min_x1", {bus.hi, bus.lo}, 64'hFFFF_FFFF_8000_0000);

    // Back-to-back with mult_start held high
    @(negedge clk);
    bus.A          = 32'hFFFF_FFFF;
    bus.B          = 32'hFFFF_FFFF;
    bus.mult_start = 1'b1;
    @(negedge clk);
    bus.A = 32'h0001_2345;
    bus.B = 32'h0;
    wait_done(cyc);
    chk("lat_b2b_first", 64'(cyc), 64'(N));
    chk("res_m1xm1", {bus.hi, bus.lo}, 64'h0000_0000_0000_0001);
    wait_done(cyc2);
    bus.mult_start = 1'b0;
    chk("b2b_spacing", 64'(cyc2), 64'(N + 2));
    chk("res_x0", {bus.hi, bus.lo}, 64'h0);
    repeat (3) @(negedge clk);
    chk("no_extra_start", {62'h0, bus.busy, bus.done}, 64'h0);

    // Second pulse in RUN is ignored
    do_start(32'd5, 32'd6);
    repeat (5) @(negedge clk);
    bus.A          = 32'd9;
    bus.B          = 32'd9;
    bus.mult_start = 1'b1;
    @(negedge clk);
    bus.mult_start = 1'b0;
    wait_done(cyc);
    chk("lat_ignore", 64'(cyc + 6), 64'(N));
    chk("res_5x6", {bus.hi, bus.lo}, 64'd30);

    // Reset at RUN cycle 10
    do_start(32'd100, 32'd100);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrun_reset_hilo", {bus.hi, bus.lo}, 64'h0);
    chk("midrun_reset_busy", {63'h0, bus.busy}, 64'h0);
    @(negedge clk);
    reset    = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < N + 5; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    chk("no_done_after_reset", 64'(done_cnt), 64'h0);
    chk("hilo_stay_zero", {bus.hi, bus.lo}, 64'h0);
    do_start(32'd100, 32'd100);
    wait_done(cyc);
    chk("lat_fresh", 64'(cyc), 64'(N));
    chk("res_100x100", {bus.hi, bus.lo}, 64'd10000);

`ifdef MULT_UNSIGNED_EN
    bus.mult_unsigned = 1'b1;
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("lat_multu", 64'(cyc), 64'd33);
    chk("res_multu", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    bus.mult_unsigned = 1'b0;
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc);
    chk("res_mult_signed33", {bus.hi, bus.lo}, 64'h0000_0000_0000_0001);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
